// File: rtl/data_memory.sv
// Byte-addressable, big-endian data memory for a MIPS-style datapath.
// Loads are combinational and have zero latency. Stores commit on the rising
// clock edge and write only the byte lanes they address. An illegal request
// raises access_error in the same cycle and latches error_sticky at the next
// edge. An asynchronous reset clears every word and the sticky flag.
module data_memory #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_write_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        load_unsigned,
   output logic [31:0] mem_read_data,
   output logic        access_error,
   output logic        error_sticky
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_t;

   logic [31:0]   mem [DEPTH_WORDS];

   size_t         size;
   logic [AW-1:0] word_idx;
   logic [1:0]    byte_off;
   logic          request;
   logic          in_range;
   logic          misaligned;
   logic [31:0]   cur_word;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   lane_mask;
   logic [31:0]   lane_data;
   logic [31:0]   merged_word;
   logic          write_en;

   assign size     = size_t'(mem_size);
   assign word_idx = mem_address[AW+1:2];
   assign byte_off = mem_address[1:0];
   assign request  = mem_read | mem_write;
   // Anything at or above 4*DEPTH_WORDS is rejected rather than wrapped into the array.
   assign in_range = ((mem_address >> (AW + 2)) == 32'd0);
   assign cur_word = mem[word_idx];
   assign write_en = mem_write & ~access_error;

   // Classify the current request as legal or illegal.
   always_comb begin
      misaligned = 1'b0;
      case (size)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = byte_off[0];
         SIZE_WORD: misaligned = (byte_off != 2'b00);
         SIZE_RSVD: misaligned = 1'b1;
         default:   misaligned = 1'b1;
      endcase
      access_error = request & (misaligned | ~in_range | (mem_read & mem_write));
   end

   // Select the addressed big-endian lane and extend it to 32 bits.
   always_comb begin
      sel_byte      = 8'h00;
      sel_half      = 16'h0000;
      mem_read_data = 32'h0;
      case (byte_off)
         2'd0:    sel_byte = cur_word[31:24];
         2'd1:    sel_byte = cur_word[23:16];
         2'd2:    sel_byte = cur_word[15:8];
         default: sel_byte = cur_word[7:0];
      endcase
      sel_half = byte_off[1] ? cur_word[15:0] : cur_word[31:16];
      if (mem_read && !access_error) begin
         case (size)
            SIZE_BYTE: mem_read_data = load_unsigned ? {24'h0, sel_byte}
                                                     : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: mem_read_data = load_unsigned ? {16'h0, sel_half}
                                                     : {{16{sel_half[15]}}, sel_half};
            SIZE_WORD: mem_read_data = cur_word;
            default:   mem_read_data = 32'h0;
         endcase
      end
   end

   // Build the lane mask and the replicated store data, then merge them into the old word.
   always_comb begin
      lane_mask = 32'h0;
      lane_data = 32'h0;
      case (size)
         SIZE_BYTE: begin
            lane_mask = 32'hFF00_0000 >> {byte_off, 3'b000};
            lane_data = {4{mem_write_data[7:0]}};
         end
         SIZE_HALF: begin
            lane_mask = byte_off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            lane_data = {2{mem_write_data[15:0]}};
         end
         SIZE_WORD: begin
            lane_mask = 32'hFFFF_FFFF;
            lane_data = mem_write_data;
         end
         default: begin
            lane_mask = 32'h0;
            lane_data = 32'h0;
         end
      endcase
      merged_word = (cur_word & ~lane_mask) | (lane_data & lane_mask);
   end

   // Memory array: asynchronous clear, otherwise commit legal stores on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (write_en) begin
         mem[word_idx] <= merged_word;
      end
   end

   // Sticky error flag: set by any illegal request, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error_sticky <= 1'b0;
      end else if (access_error) begin
         error_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge that commits
// stores.
module tb_data_memory;

   localparam int DEPTH_WORDS = 256;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   logic        clk;
   logic        rst;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        load_unsigned;
   logic [31:0] mem_read_data;
   logic        access_error;
   logic        error_sticky;

   int tests_run;
   int tests_failed;

   data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_size       (mem_size),
      .load_unsigned  (load_unsigned),
      .mem_read_data  (mem_read_data),
      .access_error   (access_error),
      .error_sticky   (error_sticky)
   );

   // 10 ns clock: rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request on the falling edge and let the combinational outputs settle.
   task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] data);
      @(negedge clk);
      mem_read       = rd;
      mem_write      = wr;
      mem_size       = size;
      load_unsigned  = uns;
      mem_address    = addr;
      mem_write_data = data;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Directed sequence.
   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst            = 1'b1;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_size       = SZ_W;
      load_unsigned  = 1'b0;
      mem_address    = 32'h0;
      mem_write_data = 32'h0;

      // Reset state, read while reset is held
      apply_stimulus(1, 0, SZ_W, 0, 32'h10, 32'h0);
      check_output("reset_read",   mem_read_data, 32'h0);
      check_output("reset_err",    {31'h0, access_error}, 32'h0);
      check_output("reset_sticky", {31'h0, error_sticky}, 32'h0);
      rst = 1'b0;

      // Word store then load
      apply_stimulus(0, 1, SZ_W, 0, 32'h10, 32'h8001_7F80);
      check_output("sw_err", {31'h0, access_error}, 32'h0);
      check_output("sw_no_early_read", mem_read_data, 32'h0);
      apply_stimulus(1, 0, SZ_W, 0, 32'h10, 32'h0);
      check_output("lw_10",     mem_read_data, 32'h8001_7F80);
      check_output("lw_10_err", {31'h0, access_error}, 32'h0);

      // Byte/half extension
      apply_stimulus(1, 0, SZ_B, 0, 32'h10, 32'h0);
      check_output("lb_10",  mem_read_data, 32'hFFFF_FF80);
      apply_stimulus(1, 0, SZ_B, 1, 32'h10, 32'h0);
      check_output("lbu_10", mem_read_data, 32'h0000_0080);
      apply_stimulus(1, 0, SZ_H, 0, 32'h12, 32'h0);
      check_output("lh_12",  mem_read_data, 32'h0000_7F80);
      apply_stimulus(1, 0, SZ_H, 0, 32'h10, 32'h0);
      check_output("lh_10",  mem_read_data, 32'hFFFF_8001);
      apply_stimulus(1, 0, SZ_H, 1, 32'h10, 32'h0);
      check_output("lhu_10", mem_read_data, 32'h0000_8001);
      apply_stimulus(1, 0, SZ_B, 1, 32'h13, 32'h0);
      check_output("lbu_13", mem_read_data, 32'h0000_0080);
      apply_stimulus(1, 0, SZ_B, 0, 32'h12, 32'h0);
      check_output("lb_12",  mem_read_data, 32'h0000_007F);
      apply_stimulus(1, 1'b0, SZ_W, 1, 32'h10, 32'h0);
      check_output("lw_ignores_uns", mem_read_data, 32'h8001_7F80);

      // Partial stores
      apply_stimulus(0, 1, SZ_B, 0, 32'h11, 32'hAABB_CCDD);
      apply_stimulus(1, 0, SZ_W, 0, 32'h10, 32'h0);
      check_output("sb_11", mem_read_data, 32'h80DD_7F80);
      apply_stimulus(0, 1, SZ_H, 0, 32'h12, 32'h0000_1234);
      apply_stimulus(1, 0, SZ_W, 0, 32'h10, 32'h0);
      check_output("sh_12", mem_read_data, 32'h80DD_1234);
      check_output("sticky_before_err", {31'h0, error_sticky}, 32'h0);

      // Misaligned store is suppressed and latches the sticky flag
      apply_stimulus(0, 1, SZ_W, 0, 32'h13, 32'hFFFF_FFFF);
      check_output("sw_13_err", {31'h0, access_error}, 32'h1);
      check_output("sticky_pre_edge", {31'h0, error_sticky}, 32'h0);
      apply_stimulus(1, 0, SZ_W, 0, 32'h10, 32'h0);
      check_output("sw_13_no_write", mem_read_data, 32'h80DD_1234);
      check_output("sticky_set", {31'h0, error_sticky}, 32'h1);
      apply_stimulus(1, 0, SZ_H, 0, 32'h11, 32'h0);
      check_output("lh_11_data", mem_read_data, 32'h0);
      check_output("lh_11_err",  {31'h0, access_error}, 32'h1);

      // Range and conflict
      apply_stimulus(1, 0, SZ_W, 0, 32'h400, 32'h0);
      check_output("lw_oor_err",  {31'h0, access_error}, 32'h1);
      check_output("lw_oor_data", mem_read_data, 32'h0);
      apply_stimulus(1, 0, SZ_W, 0, 32'h3FC, 32'h0);
      check_output("lw_top_err",  {31'h0, access_error}, 32'h0);
      check_output("lw_top_data", mem_read_data, 32'h0);
      apply_stimulus(0, 1, SZ_W, 0, 32'h410, 32'hFFFF_FFFF);
      check_output("sw_oor_err", {31'h0, access_error}, 32'h1);
      apply_stimulus(1, 1, SZ_W, 0, 32'h10, 32'h0);
      check_output("rdwr_err",  {31'h0, access_error}, 32'h1);
      check_output("rdwr_data", mem_read_data, 32'h0);
      apply_stimulus(1, 0, SZ_W, 0, 32'h10, 32'h0);
      check_output("no_alias_no_conflict_write", mem_read_data, 32'h80DD_1234);
      apply_stimulus(1, 0, SZ_R, 0, 32'h10, 32'h0);
      check_output("rsvd_err",  {31'h0, access_error}, 32'h1);
      check_output("rsvd_data", mem_read_data, 32'h0);
      apply_stimulus(0, 0, SZ_W, 0, 32'h13, 32'h0);
      check_output("idle_err",  {31'h0, access_error}, 32'h0);
      check_output("idle_data", mem_read_data, 32'h0);

      // Asynchronous reset between edges
      apply_stimulus(1, 0, SZ_W, 0, 32'h10, 32'h0);
      check_output("pre_rst_read", mem_read_data, 32'h80DD_1234);
      #2;
      rst = 1'b1;
      #1;
      check_output("async_rst_read",   mem_read_data, 32'h0);
      check_output("async_rst_sticky", {31'h0, error_sticky}, 32'h0);
      rst = 1'b0;

      // Store whose edge coincides with reset is blocked
      apply_stimulus(0, 1, SZ_W, 0, 32'h20, 32'h5A5A_5A5A);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply_stimulus(1, 0, SZ_W, 0, 32'h20, 32'h0);
      check_output("rst_blocks_store", mem_read_data, 32'h0);
      check_output("rst_sticky_clear", {31'h0, error_sticky}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
